ena_scheduler: RTL

- Generates the per-signal enable vector `ena` that drives the synchronous model of an asynchronous circuit. Bit order is environment inputs first, then gates.
- Each cycle it chooses which excited signals fire: exactly one (interleaving semantics) or all excited signals (maximal parallelism).
- It also tracks fired transitions and flags deadlock or budget exhaustion.
- Sits beside the generated `circuit` module in the testbench/emulation top, between the excitation logic and the `ena` port.

---
 rtl/ena_sched_pkg.sv | 30 +++
 rtl/ena_scheduler_if.sv | 42 ++++
 rtl/ena_rr_pick.sv | 36 +++
 rtl/ena_scheduler.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/ena_sched_pkg.sv
// Shared types and constants for the enable scheduler: scheduling modes,
// FSM states, LFSR polynomial and the index-width helper.
package ena_sched_pkg;

  typedef enum logic [1:0] {
    MODE_RR   = 2'd0,
    MODE_RAND = 2'd1,
    MODE_PAR  = 2'd2,
    MODE_STEP = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // An index into an n-wide vector, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Right-shifting Galois LFSR step.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/ena_scheduler_if.sv
// Bundle between the excitation logic / environment and the enable scheduler,
// including the scheduler's debug view of its FSM state and LFSR.
interface ena_scheduler_if #(
  parameter int N_ENA = 8,
  parameter int CNT_W = 32
);
  import ena_sched_pkg::*;

  localparam int IDX_W = idx_w(N_ENA);

  logic               run;
  logic [1:0]         mode;
  logic               step;
  logic [N_ENA-1:0]   excited;
  logic [N_ENA-1:0]   mask;
  logic [CNT_W-1:0]   budget;

  // fire_valid qualifies ena and fire_idx in the same cycle; there is no
  // ready: the circuit consumes every enable it is given.
  logic [N_ENA-1:0]   ena;
  logic               fire_valid;
  logic [IDX_W-1:0]   fire_idx;
  logic [CNT_W-1:0]   fire_count;
  logic               deadlock;
  logic               done;

  state_e             dbg_state;
  logic [15:0]        dbg_lfsr;

  modport master (
    output run, mode, step, excited, mask, budget,
    input  ena, fire_valid, fire_idx, fire_count, deadlock, done,
    input  dbg_state, dbg_lfsr
  );

  modport slave (
    input  run, mode, step, excited, mask, budget,
    output ena, fire_valid, fire_idx, fire_count, deadlock, done,
    output dbg_state, dbg_lfsr
  );

endinterface

// File: rtl/ena_rr_pick.sv
// Rotating-priority picker: grants the first set bit of cand at or after
// start, wrapping past the top back to bit 0.
module ena_rr_pick #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     cand,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int               j;
  logic [IDX_W-1:0] j_idx;

  // Walk offsets from the farthest down to zero so the nearest hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |cand;
    j     = 0;
    j_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      j_idx = IDX_W'(j);
      if (cand[j_idx]) begin
        grant        = '0;
        grant[j_idx] = 1'b1;
        idx          = j_idx;
      end
    end
  end

endmodule

// File: rtl/ena_scheduler.sv
// Enable scheduler for the synchronous model of an asynchronous circuit:
// picks which excited signals fire each cycle and tracks progress/deadlock.
module ena_scheduler
  import ena_sched_pkg::*;
#(
  parameter int          N_ENA       = 8,
  parameter int          CNT_W       = 32,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          STALL_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  ena_scheduler_if.slave   bus
);

  localparam int IDX_W   = idx_w(N_ENA);
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               dl_q, dl_d;
  logic               done_q, done_d;

  logic [N_ENA-1:0]   cand;
  logic [N_ENA-1:0]   grant;
  logic [N_ENA-1:0]   ena_c;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   start_idx;
  logic [IDX_W-1:0]   idx_c;
  logic [31:0]        rand_prod;
  logic               any_cand;
  logic               active;
  logic               step_ok;
  logic               fire;

  assign cand      = bus.excited & bus.mask;
  assign active    = (state_q == RUN) && bus.run;
  assign step_ok   = (mode_q != MODE_STEP) || bus.step;
  assign fire      = active && step_ok && any_cand;
  // Scale the LFSR into [0, N_ENA) without a divider.
  assign rand_prod = {16'h0000, lfsr_q} * 32'(N_ENA);
  assign start_idx = (mode_q == MODE_RAND) ? IDX_W'(rand_prod >> 16) : ptr_q;

  ena_rr_pick #(
    .N     (N_ENA),
    .IDX_W (IDX_W)
  ) u_pick (
    .cand  (cand),
    .start (start_idx),
    .grant (grant),
    .idx   (pick_idx),
    .any   (any_cand)
  );

  // Zero-latency enable: a registered enable would be one cycle stale.
  always_comb begin
    ena_c = '0;
    idx_c = '0;
    if (active) begin
      if (mode_q == MODE_PAR) begin
        ena_c = cand;
      end else if (fire) begin
        ena_c = grant;
        idx_c = pick_idx;
      end
    end
  end

  assign bus.ena        = ena_c;
  assign bus.fire_valid = |ena_c;
  assign bus.fire_idx   = idx_c;
  assign bus.fire_count = cnt_q;
  assign bus.deadlock   = dl_q;
  assign bus.done       = done_q;
  assign bus.dbg_state  = state_q;
  assign bus.dbg_lfsr   = lfsr_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    ptr_d   = ptr_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    dl_d    = dl_q;
    done_d  = done_q;
    if (!bus.run) begin
      state_d = IDLE;
      dl_d    = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
          mode_d  = mode_e'(bus.mode);
          cnt_d   = '0;
          stall_d = '0;
          dl_d    = 1'b0;
          done_d  = 1'b0;
        end
        RUN: begin
          lfsr_d = lfsr_next(lfsr_q);
          if (fire) begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            stall_d = '0;
            if (mode_q == MODE_RR || mode_q == MODE_STEP)
              ptr_d = (pick_idx == IDX_W'(N_ENA - 1)) ? '0 : pick_idx + 1'b1;
            if (bus.budget != '0 && (cnt_q + 1'b1) == bus.budget) done_d = 1'b1;
          end else if (step_ok) begin
            // A dropped step counts as a stall; an idle step-mode cycle does not.
            if (stall_q != STALL_W'(STALL_LIMIT)) stall_d = stall_q + 1'b1;
            if ((stall_q + 1'b1) == STALL_W'(STALL_LIMIT)) dl_d = 1'b1;
          end
          if (dl_d || done_d) state_d = HALT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_RR;
      ptr_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      cnt_q   <= '0;
      stall_q <= '0;
      dl_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      ptr_q   <= ptr_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      dl_q    <= dl_d;
      done_q  <= done_d;
    end
  end

endmodule
